lvds_link_ctrl: RTL and testbench

LVDS_LINK_CTRL -- requirements
Module: lvds_link_ctrl

---
 rtl/lvds_link_pkg.sv | 19 +
 rtl/lvds_link_rx.sv | 159 +++++++++++++++
 rtl/lvds_link_ctrl.sv | 140 ++++++++++++++
 tb/tb_lvds_link_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS serial link controller.
// Holds the frame header codes and the TX/RX state encodings.
package lvds_link_pkg;

    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_CTRL = 2'b01;

    typedef enum logic {
        TX_TRAIN = 1'b0,
        TX_RUN   = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_HUNT   = 2'd0,
        RX_CHECK  = 2'd1,
        RX_LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/lvds_link_rx.sv
// Receive side of the LVDS link: frame alignment, lock tracking, payload output.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_bit              serial input, already synchronous to clk
//   m_data, m_valid     received payload and its one-cycle strobe
//   link_up             high while aligned (LOCKED)
//   err_cnt, data_cnt   saturating statistics (only built with LVDS_LINK_STATS_EN)
module lvds_link_rx
    import lvds_link_pkg::*;
#(
    parameter int unsigned       WORD_W       = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD    = WORD_W'(8'hBC),
    parameter int unsigned       LOCK_MATCHES = 4,
    parameter int unsigned       ERR_LIMIT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    output logic              link_up,
    output logic [15:0]       err_cnt,
    output logic [15:0]       data_cnt
);

    localparam int unsigned F    = WORD_W + 2;
    localparam int unsigned PH_W = $clog2(F);
    localparam int unsigned MC_W = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned EC_W = $clog2(ERR_LIMIT + 1);
    localparam logic [F-1:0]    SYNC_FRAME = {HDR_CTRL, SYNC_WORD};
    localparam logic [PH_W-1:0] LAST_PH    = PH_W'(F - 1);

    rx_state_e        st_q, st_d;
    logic [F-2:0]     sr_q;
    logic [F-1:0]     win;
    logic [1:0]       hdr;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    logic [EC_W-1:0]  run_q, run_d;
    logic             frame_end, sync_hit, take_data, bad_hdr;
    logic [WORD_W-1:0] m_data_q;
    logic             m_valid_q, link_up_q;

    // F-bit window: stored history plus the bit on the wire now, so a frame is
    // judged in the cycle its last bit arrives.
    assign win       = {sr_q, rx_bit};
    assign hdr       = win[F-1 -: 2];
    assign sync_hit  = (win == SYNC_FRAME);
    assign frame_end = (ph_q == LAST_PH);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) st_q <= RX_HUNT;
        else        st_q <= st_d;
    end

    // Output/strobe decode for the locked frame checks
    always_comb begin
        take_data = 1'b0;
        bad_hdr   = 1'b0;
        if (st_q == RX_LOCKED && frame_end) begin
            take_data = (hdr == HDR_DATA);
            bad_hdr   = (hdr != HDR_DATA) && (hdr != HDR_CTRL);
        end
    end

    // Next-state logic
    always_comb begin
        st_d  = st_q;
        ph_d  = frame_end ? '0 : ph_q + PH_W'(1);
        mc_d  = mc_q;
        run_d = run_q;
        case (st_q)
            RX_HUNT: begin
                // The matching cycle is treated as frame end; next bit starts a frame.
                if (sync_hit) begin
                    st_d = RX_CHECK;
                    ph_d = '0;
                    mc_d = MC_W'(1);
                end
            end
            RX_CHECK: begin
                if (frame_end) begin
                    if (!sync_hit) begin
                        st_d = RX_HUNT;
                    end else if (mc_q == MC_W'(LOCK_MATCHES)) begin
                        // Lock on the LOCK_MATCHES-th SYNC following the hunting match.
                        st_d  = RX_LOCKED;
                        run_d = '0;
                    end else begin
                        mc_d = mc_q + MC_W'(1);
                    end
                end
            end
            RX_LOCKED: begin
                if (frame_end) begin
                    if (bad_hdr) begin
                        if (run_q == EC_W'(ERR_LIMIT - 1)) begin
                            st_d  = RX_HUNT;
                            run_d = '0;
                        end else begin
                            run_d = run_q + EC_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            end
            default: st_d = RX_HUNT;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q      <= '0;
            ph_q      <= '0;
            mc_q      <= '0;
            run_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            link_up_q <= 1'b0;
        end else begin
            sr_q      <= win[F-2:0];
            ph_q      <= ph_d;
            mc_q      <= mc_d;
            run_q     <= run_d;
            m_valid_q <= take_data;
            if (take_data) m_data_q <= win[WORD_W-1:0];
            link_up_q <= (st_d == RX_LOCKED);
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign link_up = link_up_q;

`ifdef LVDS_LINK_STATS_EN
    logic [15:0] err_cnt_q, data_cnt_q;

    // Saturating statistics, only advanced while locked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            data_cnt_q <= '0;
        end else begin
            if (bad_hdr && err_cnt_q != 16'hFFFF)     err_cnt_q  <= err_cnt_q + 16'd1;
            if (take_data && data_cnt_q != 16'hFFFF)  data_cnt_q <= data_cnt_q + 16'd1;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign data_cnt = data_cnt_q;
`else
    assign err_cnt  = '0;
    assign data_cnt = '0;
`endif

endmodule

// File: rtl/lvds_link_ctrl.sv
// LVDS serial link controller: TX framer/trainer plus the RX aligner sub-module.
// Frames are MSB first: 2-bit header then WORD_W payload bits.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   s_data/s_valid/s_ready  TX payload handshake (s_ready once per frame in RUN)
//   tx_retrain           one-cycle request for a new training burst
//   tx_bit, tx_trained   serial output, TX past training
//   rx_bit               serial input
//   m_data/m_valid       received payload
//   link_up              RX locked
//   err_cnt, data_cnt    statistics, built only when LVDS_LINK_STATS_EN is defined
module lvds_link_ctrl
    import lvds_link_pkg::*;
#(
    parameter int unsigned       WORD_W       = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD    = WORD_W'(8'hBC),
    parameter logic [WORD_W-1:0] IDLE_WORD    = WORD_W'(8'h3C),
    parameter int unsigned       TRAIN_FRAMES = 16,
    parameter int unsigned       LOCK_MATCHES = 4,
    parameter int unsigned       ERR_LIMIT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              tx_retrain,
    output logic              tx_bit,
    output logic              tx_trained,
    input  logic              rx_bit,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    output logic              link_up,
    output logic [15:0]       err_cnt,
    output logic [15:0]       data_cnt
);

    localparam int unsigned F     = WORD_W + 2;
    localparam int unsigned BIT_W = $clog2(F);
    localparam int unsigned FRM_W = $clog2(TRAIN_FRAMES + 1);
    localparam logic [F-1:0]     SYNC_FRAME = {HDR_CTRL, SYNC_WORD};
    localparam logic [F-1:0]     IDLE_FRAME = {HDR_CTRL, IDLE_WORD};
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(F - 1);

    tx_state_e        tx_state_q, tx_state_d;
    logic [BIT_W-1:0] bitcnt_q;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             retrain_pend_q, retrain_pend_d;
    logic [F-1:0]     tx_sr_q;
    logic [F-1:0]     next_frame;
    logic             tx_bit_q, tx_trained_q;
    logic             frame_end, hs;

    assign frame_end = (bitcnt_q == LAST_BIT);
    assign hs        = s_valid && s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) tx_state_q <= TX_TRAIN;
        else        tx_state_q <= tx_state_d;
    end

    // Next-state and next-frame selection, decided only at frame boundaries
    always_comb begin
        tx_state_d     = tx_state_q;
        frm_cnt_d      = frm_cnt_q;
        retrain_pend_d = retrain_pend_q | tx_retrain;
        next_frame     = IDLE_FRAME;
        if (frame_end) begin
            if (hs) begin
                // An accepted payload always goes out; a pending retrain waits a frame.
                next_frame = {HDR_DATA, s_data};
            end else if (retrain_pend_d) begin
                tx_state_d     = TX_TRAIN;
                frm_cnt_d      = '0;
                retrain_pend_d = 1'b0;
                next_frame     = SYNC_FRAME;
            end else if (tx_state_q == TX_TRAIN) begin
                if (frm_cnt_q == FRM_W'(TRAIN_FRAMES - 1)) begin
                    tx_state_d = TX_RUN;
                    frm_cnt_d  = '0;
                    next_frame = IDLE_FRAME;
                end else begin
                    frm_cnt_d  = frm_cnt_q + FRM_W'(1);
                    next_frame = SYNC_FRAME;
                end
            end
        end
    end

    // Output decode: payload slot offered on the last bit of each RUN frame
    always_comb begin
        s_ready = (tx_state_q == TX_RUN) && frame_end;
    end

    // Serializer datapath; tx_sr_q holds the bits still to be sent, next one at MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitcnt_q       <= '0;
            frm_cnt_q      <= '0;
            retrain_pend_q <= 1'b0;
            tx_sr_q        <= SYNC_FRAME << 1;
            tx_bit_q       <= 1'b0;
            tx_trained_q   <= 1'b0;
        end else begin
            frm_cnt_q      <= frm_cnt_d;
            retrain_pend_q <= retrain_pend_d;
            tx_trained_q   <= (tx_state_d == TX_RUN);
            if (frame_end) begin
                bitcnt_q <= '0;
                tx_bit_q <= next_frame[F-1];
                tx_sr_q  <= next_frame << 1;
            end else begin
                bitcnt_q <= bitcnt_q + BIT_W'(1);
                tx_bit_q <= tx_sr_q[F-1];
                tx_sr_q  <= tx_sr_q << 1;
            end
        end
    end

    assign tx_bit     = tx_bit_q;
    assign tx_trained = tx_trained_q;

    lvds_link_rx #(
        .WORD_W       (WORD_W),
        .SYNC_WORD    (SYNC_WORD),
        .LOCK_MATCHES (LOCK_MATCHES),
        .ERR_LIMIT    (ERR_LIMIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_bit   (rx_bit),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .link_up  (link_up),
        .err_cnt  (err_cnt),
        .data_cnt (data_cnt)
    );

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Directed bench for lvds_link_ctrl with rx_bit looped back from tx_bit.
module tb_lvds_link_ctrl;

    localparam logic [9:0] SYNC_FR = 10'b01_1011_1100;
    localparam logic [9:0] IDLE_FR = 10'b01_0011_1100;
`ifdef LVDS_LINK_STATS_EN
    localparam int EXP_DATA3 = 3;
    localparam int EXP_ERR3  = 3;
`else
    localparam int EXP_DATA3 = 0;
    localparam int EXP_ERR3  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        tx_retrain;
    logic        tx_bit;
    logic        tx_trained;
    logic        rx_bit;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        link_up;
    logic [15:0] err_cnt;
    logic [15:0] data_cnt;
    logic        force_ones;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    int cyc   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Loopback, optionally forced high to corrupt headers
    assign rx_bit = force_ones ? 1'b1 : tx_bit;

    lvds_link_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .tx_retrain (tx_retrain),
        .tx_bit     (tx_bit),
        .tx_trained (tx_trained),
        .rx_bit     (rx_bit),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .link_up    (link_up),
        .err_cnt    (err_cnt),
        .data_cnt   (data_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture one frame starting at its first bit; tr reports any tx_trained high.
    task automatic get_frame(output logic [9:0] f, output logic tr);
        f  = '0;
        tr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            f  = {f[8:0], tx_bit};
            tr = tr | tx_trained;
            step();
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!s_ready && n < 40) begin
            step();
            n++;
        end
        chk("s_ready_wait", 32'(s_ready), 1);
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_tx_bit"},     32'(tx_bit), 0);
        chk({pfx, "_s_ready"},    32'(s_ready), 0);
        chk({pfx, "_tx_trained"}, 32'(tx_trained), 0);
        chk({pfx, "_m_valid"},    32'(m_valid), 0);
        chk({pfx, "_m_data"},     32'(m_data), 0);
        chk({pfx, "_link_up"},    32'(link_up), 0);
        chk({pfx, "_err_cnt"},    32'(err_cnt), 0);
        chk({pfx, "_data_cnt"},   32'(data_cnt), 0);
    endtask

    // Scoreboard: push on handshake, pop on received payload
    always @(negedge clk) begin
        if (rst_n && s_valid && s_ready) exp_q.push_back(s_data);
        if (m_valid) begin
            rx_cnt++;
            if (exp_q.size() == 0) chk("m_valid_unexpected", 32'(exp_q.size()), 1);
            else                   chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [9:0] f;
        logic       tr;
        logic       acc;
        int         n, c_prev, r0, badf;
        logic [7:0] words [3];

        words = '{8'h11, 8'h22, 8'h33};
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; tx_retrain = 1'b0; force_ones = 1'b0;
        c_prev = 0;
        repeat (3) step();
        chk_reset("rst");

        // Training burst and RX lock
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            get_frame(f, tr);
            chk("train_frame", 32'(f), 32'(SYNC_FR));
            chk("train_trained_low", 32'(tr), 0);
            chk("train_link_up", 32'(link_up), 32'(k >= 5));
        end
        chk("trained_after", 32'(tx_trained), 1);
        get_frame(f, tr);
        chk("first_run_idle", 32'(f), 32'(IDLE_FR));

        // Three payloads, one slot per frame
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = words[i];
            wait_ready();
            if (i > 0) chk("ready_gap", 32'(cyc - c_prev), 10);
            c_prev = cyc;
            step();
            if (i == 2) s_valid = 1'b0;
        end
        repeat (9) step();
        chk("lat_before", 32'(m_valid), 0);
        step();
        chk("lat_hit", 32'(m_valid), 1);
        chk("lat_data", 32'(m_data), 32'h33);
        repeat (20) step();
        chk("rx_count", 32'(rx_cnt), 3);
        chk("sb_empty", 32'(exp_q.size()), 0);
        chk("data_cnt", 32'(data_cnt), 32'(EXP_DATA3));

        // Idle traffic
        r0 = rx_cnt;
        acc = 1'b1;
        repeat (60) begin
            step();
            acc = acc & link_up;
        end
        chk("idle_link_up", 32'(acc), 1);
        chk("idle_no_data", 32'(rx_cnt), 32'(r0));
        wait_ready();
        step();
        get_frame(f, tr);
        chk("idle_frame", 32'(f), 32'(IDLE_FR));

        // Retrain mid-frame
        wait_ready();
        step();
        f = '0;
        for (int i = 0; i < 10; i++) begin
            f = {f[8:0], tx_bit};
            tx_retrain = (i == 4);
            step();
        end
        tx_retrain = 1'b0;
        chk("retrain_cur_frame", 32'(f), 32'(IDLE_FR));
        badf = 0;
        acc  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            get_frame(f, tr);
            if (f != SYNC_FR) badf++;
            acc = acc | tr;
        end
        chk("retrain_sync_frames", 32'(badf), 0);
        chk("retrain_trained_low", 32'(acc), 0);
        chk("retrain_trained_back", 32'(tx_trained), 1);
        chk("retrain_link_up", 32'(link_up), 1);

        // Three bad headers drop lock
        wait_ready();
        step();
        force_ones = 1'b1;
        repeat (29) step();
        chk("bad_link_still_up", 32'(link_up), 1);
        step();
        chk("bad_link_down", 32'(link_up), 0);
        chk("bad_err_cnt", 32'(err_cnt), 32'(EXP_ERR3));
        force_ones = 1'b0;
        acc = 1'b0;
        repeat (60) begin
            step();
            acc = acc | link_up;
        end
        chk("hunt_no_false_lock", 32'(acc), 0);
        tx_retrain = 1'b1;
        step();
        tx_retrain = 1'b0;
        n = 0;
        while (!link_up && n < 400) begin
            step();
            n++;
        end
        chk("relock", 32'(link_up), 1);
        chk("relock_not_early", 32'(n >= 45), 1);
        chk("relock_data_cnt", 32'(data_cnt), 32'(EXP_DATA3));

        // Reset in the middle of a data frame
        n = 0;
        while (!tx_trained && n < 400) begin
            step();
            n++;
        end
        chk("trained_wait", 32'(tx_trained), 1);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        wait_ready();
        step();
        s_valid = 1'b0;
        chk("mid_rst_hdr_msb", 32'(tx_bit), 1);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        chk_reset("mid_rst");
        rst_n = 1'b1;
        exp_q.delete();
        get_frame(f, tr);
        chk("post_reset_sync", 32'(f), 32'(SYNC_FR));
        repeat (60) step();
        chk("final_rx_count", 32'(rx_cnt), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
